// File: rtl/arm_mem_pkg.sv
// Shared constants and types for the ARM core memory responder.
package arm_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;  // MOV r0, r0

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_byte_loader.sv
// Byte-serial instruction image loader: assembles little-endian words and
// holds the core in reset until the last byte of the image is accepted.
module mem_byte_loader
  import arm_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_valid,
  input  logic [7:0]                         load_byte,
  input  logic                               load_last,
  output logic                               load_ready,
  output logic                               core_reset,
  output logic                               load_error,
  output logic                               run,
  output logic                               wr_en,
  output logic [idx_width(IMEM_WORDS)-1:0]   wr_addr,
  output logic [31:0]                        wr_data
);

  localparam int IW = idx_width(IMEM_WORDS);

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [IW:0] word_addr;   // one extra bit so it can sit at IMEM_WORDS
  logic [31:0] asm_reg;
  logic        accept;
  logic        full;
  logic [31:0] merged;

  assign accept = load_valid & load_ready;
  assign full   = (word_addr == (IW + 1)'(IMEM_WORDS));
  // asm_reg is cleared after every committed word, so a short final word is zero-padded
  assign merged = asm_reg | ({24'b0, load_byte} << {byte_cnt, 3'b000});

  assign wr_en   = accept & ~full & ((byte_cnt == 2'd3) | load_last);
  assign wr_addr = word_addr[IW-1:0];
  assign wr_data = merged;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    if (accept && load_last) state_nxt = RUN;
  end

  always_comb begin
    load_ready = (state == LOAD);
    core_reset = (state == LOAD);
    run        = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      word_addr  <= '0;
      asm_reg    <= 32'd0;
      load_error <= 1'b0;
    end else if (accept) begin
      if (full) begin
        load_error <= 1'b1;
      end else begin
        if (load_last && byte_cnt != 2'd3) load_error <= 1'b1;
        if (wr_en) begin
          asm_reg   <= 32'd0;
          byte_cnt  <= 2'd0;
          word_addr <= word_addr + 1'b1;
        end else begin
          asm_reg  <= merged;
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/arm_mem_responder.sv
// Instruction and data memories for the single-cycle ARM core, with a
// byte-serial image loader that gates the core's reset.
module arm_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  input  logic        LoadValid,
  input  logic [7:0]  LoadByte,
  input  logic        LoadLast,
  output logic        LoadReady,
  output logic        CoreReset,
  output logic        LoadError
);

  localparam int IW = idx_width(IMEM_WORDS);
  localparam int DW = idx_width(DMEM_WORDS);

  logic [31:0]   imem [IMEM_WORDS];
  logic [31:0]   dmem [DMEM_WORDS];
  logic          run;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          instr_hit;
  logic          data_hit;
  logic          unused_lsbs;

  mem_byte_loader #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_loader (
    .clk       (clk),
    .rst_n     (Reset),
    .load_valid(LoadValid),
    .load_byte (LoadByte),
    .load_last (LoadLast),
    .load_ready(LoadReady),
    .core_reset(CoreReset),
    .load_error(LoadError),
    .run       (run),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // NOTE: memory arrays have no reset; contents survive Reset and are overwritten by the next load.
  always_ff @(posedge clk) begin
    if (wr_en) imem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (MemWrite && run && data_hit) dmem[ALUResult[DW+1:2]] <= WriteData;
  end

  assign instr_hit = (PC[31:IW+2] == '0);
  assign data_hit  = (ALUResult[31:DW+2] == '0);

  assign Instr    = instr_hit ? imem[PC[IW+1:2]] : NOP_INSTR;
  assign ReadData = data_hit ? dmem[ALUResult[DW+1:2]] : 32'd0;

  // word-aligned accesses only; the byte offset is ignored
  assign unused_lsbs = ^{PC[1:0], ALUResult[1:0]};

endmodule

// File: tb/tb_arm_mem_responder.sv
// Scoreboard bench for arm_mem_responder: loads images, then probes fetch and
// data ports against expected words queued as the stimulus is applied.
module tb_arm_mem_responder;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PC = 32'd0;
  logic [31:0] Instr;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        LoadValid = 1'b0;
  logic [7:0]  LoadByte = 8'd0;
  logic        LoadLast = 1'b0;
  logic        LoadReady;
  logic        CoreReset;
  logic        LoadError;

  always #5 clk = ~clk;

  arm_mem_responder #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .PC       (PC),
    .Instr    (Instr),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .LoadValid(LoadValid),
    .LoadByte (LoadByte),
    .LoadLast (LoadLast),
    .LoadReady(LoadReady),
    .CoreReset(CoreReset),
    .LoadError(LoadError)
  );

  typedef struct {
    string       tag;
    bit          is_data;
    logic [31:0] addr;
    logic [31:0] exp;
  } probe_t;

  probe_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag, input bit is_data, input logic [31:0] addr,
                             input logic [31:0] exp);
    probe_t p;
    p.tag = tag; p.is_data = is_data; p.addr = addr; p.exp = exp;
    sb.push_back(p);
  endtask

  task automatic drain();
    probe_t p;
    while (sb.size() > 0) begin
      p = sb.pop_front();
      @(negedge clk);
      if (p.is_data) ALUResult = p.addr;
      else           PC = p.addr;
      #1;
      check(p.tag, p.is_data ? ReadData : Instr, p.exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    check("core_reset_held", {31'd0, CoreReset}, 32'd1);
    LoadValid = 1'b1;
    LoadByte  = b;
    LoadLast  = last;
    @(posedge clk);
    #1;
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("rst_core_reset", {31'd0, CoreReset}, 32'd1);
    check("rst_load_ready", {31'd0, LoadReady}, 32'd1);
    check("rst_load_error", {31'd0, LoadError}, 32'd0);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic dmem_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ALUResult = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] img1 [8];
    logic [7:0] img4 [6];
    logic [7:0] img6 [4];
    img1 = '{8'h00, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'hA0, 8'hE3};
    img4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    img6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // 1: reset state, then a clean two-word image
    #12;
    check("por_core_reset", {31'd0, CoreReset}, 32'd1);
    check("por_load_ready", {31'd0, LoadReady}, 32'd1);
    check("por_load_error", {31'd0, LoadError}, 32'd0);
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
    check("t1_core_reset_fall", {31'd0, CoreReset}, 32'd0);
    check("t1_load_ready_low", {31'd0, LoadReady}, 32'd0);
    check("t1_load_error", {31'd0, LoadError}, 32'd0);
    expect_word("t1_imem0", 1'b0, 32'h0, 32'hE3A00000);
    expect_word("t1_imem1", 1'b0, 32'h4, 32'hE3A01001);

    // 2: fetch address decoding
    expect_word("t2_pc4", 1'b0, 32'h4, 32'hE3A01001);
    expect_word("t2_pc6", 1'b0, 32'h6, 32'hE3A01001);
    expect_word("t2_pc_oor", 1'b0, IMEM_WORDS * 4, 32'hE1A00000);
    drain();

    // 3: data writes, read-during-write, out-of-range write
    dmem_write(32'h0, 32'hA5A5A5A5);
    dmem_write(32'h10, 32'h12345678);
    @(negedge clk);
    ALUResult = 32'h10;
    WriteData = 32'hDEADBEEF;
    MemWrite  = 1'b1;
    #1;
    check("t3_rd_during_wr_old", ReadData, 32'h12345678);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("t3_rd_after_wr_new", ReadData, 32'hDEADBEEF);
    @(negedge clk);
    ALUResult = DMEM_WORDS * 4;
    WriteData = 32'h0BADF00D;
    MemWrite  = 1'b1;
    #1;
    check("t3_oor_read_zero", ReadData, 32'd0);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    expect_word("t3_oor_read_after", 1'b1, DMEM_WORDS * 4, 32'd0);
    expect_word("t3_dmem0_kept", 1'b1, 32'h0, 32'hA5A5A5A5);
    expect_word("t3_dmem4_kept", 1'b1, 32'h10, 32'hDEADBEEF);
    drain();

    // 4: truncated image
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(img4[i], i == 5);
    check("t4_load_error", {31'd0, LoadError}, 32'd1);
    check("t4_core_reset_run", {31'd0, CoreReset}, 32'd0);
    expect_word("t4_imem0", 1'b0, 32'h0, 32'h44332211);
    expect_word("t4_imem1_padded", 1'b0, 32'h4, 32'h00006655);
    drain();

    // 5: overflow past the end of instruction memory
    apply_reset();
    for (int i = 0; i < IMEM_WORDS * 4 + 2; i++) begin
      send_byte(i[7:0], i == IMEM_WORDS * 4 + 1);
      if (i == IMEM_WORDS * 4 - 1)
        check("t5_no_error_when_full", {31'd0, LoadError}, 32'd0);
      if (i == IMEM_WORDS * 4) begin
        check("t5_overflow_error", {31'd0, LoadError}, 32'd1);
        check("t5_ready_during_ovf", {31'd0, LoadReady}, 32'd1);
      end
    end
    check("t5_ready_after_last", {31'd0, LoadReady}, 32'd0);
    check("t5_core_reset_run", {31'd0, CoreReset}, 32'd0);
    expect_word("t5_imem0", 1'b0, 32'h0, 32'h03020100);
    expect_word("t5_imem1", 1'b0, 32'h4, 32'h07060504);
    expect_word("t5_imem_last", 1'b0, (IMEM_WORDS - 1) * 4, 32'hFFFEFDFC);
    drain();

    // 6: store attempt in LOAD, reset mid-load, then reload
    apply_reset();
    dmem_write(32'h10, 32'h00000000);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
    apply_reset();
    for (int i = 0; i < 4; i++) send_byte(img6[i], i == 3);
    check("t6_load_error", {31'd0, LoadError}, 32'd0);
    check("t6_core_reset_run", {31'd0, CoreReset}, 32'd0);
    expect_word("t6_imem0", 1'b0, 32'h0, 32'hDDCCBBAA);
    expect_word("t6_imem1_kept", 1'b0, 32'h4, 32'h07060504);
    expect_word("t6_no_store_in_load", 1'b1, 32'h10, 32'hDEADBEEF);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
